// File: rtl/calc_op_sequencer_if.sv
// ALU handshake bundle between the calculator sequencer (master) and the shared ALU (slave).
interface calc_op_sequencer_if;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;

    modport master (
        output alu_a, alu_b, alu_op, alu_start,
        input  alu_done, alu_result
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_start,
        output alu_done, alu_result
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Calculator control: debounces four buttons into load/op/execute commands and
// sequences the shared multi-cycle ALU through a start/done handshake.
module calc_op_sequencer #(
    parameter int unsigned DEB_CYCLES = 160000,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                       clk16M,
    input  logic                       rst,
    input  logic [7:0]                 sw,
    input  logic [3:0]                 bt,
    calc_op_sequencer_if.master        alu,
    output logic [15:0]                disp_val,
    output logic                       err
);

    localparam int unsigned DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_SHOW
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         bt_s1_q, bt_s2_q;
    logic [3:0]         lvl_q, lvl_d;
    logic [3:0]         ev_q, ev_d;
    logic [DCW-1:0]     deb_cnt_q [4];
    logic [DCW-1:0]     deb_cnt_d [4];
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         op_inc;
    logic               start_q, start_d;
    logic [15:0]        disp_q, disp_d;
    logic               err_q, err_d;
    logic [TCW-1:0]     tmo_q, tmo_d;

    // The accepted level flips on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            lvl_d[i]     = lvl_q[i];
            ev_d[i]      = 1'b0;
            if (bt_s2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                    lvl_d[i]     = ~lvl_q[i];
                    deb_cnt_d[i] = '0;
                    ev_d[i]      = ~lvl_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    assign op_inc = op_q + 2'd1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        disp_d  = disp_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (ev_q[3]) begin
                    if (op_q == 2'd3 && b_q == '0) begin
                        err_d   = 1'b1;
                        disp_d  = 16'hEEEE;
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_START;
                    end
                end else if (ev_q[2]) begin
                    op_d    = op_inc;
                    disp_d  = {14'b0, op_inc};
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (ev_q[1]) begin
                    b_d     = sw;
                    disp_d  = {8'h00, sw};
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (ev_q[0]) begin
                    a_d     = sw;
                    disp_d  = {8'h00, sw};
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // A done coinciding with the last timeout cycle still wins.
                if (alu.alu_done) begin
                    disp_d  = alu.alu_result;
                    err_d   = 1'b0;
                    state_d = ST_SHOW;
                end else if (tmo_q == TCW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    disp_d  = 16'hEEEE;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk16M) begin
        if (rst) begin
            bt_s1_q <= '0;
            bt_s2_q <= '0;
            lvl_q   <= '0;
            ev_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
            disp_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            bt_s1_q <= bt;
            bt_s2_q <= bt_s1_q;
            lvl_q   <= lvl_d;
            ev_q    <= ev_d;
            for (int unsigned i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            start_q <= start_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign alu.alu_a     = a_q;
    assign alu.alu_b     = b_q;
    assign alu.alu_op    = op_q;
    assign alu.alu_start = start_q;
    assign disp_val      = disp_q;
    assign err           = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed button scenarios checked every cycle
// against a command-level model, plus literal expectations at scenario ends.
module tb_calc_op_sequencer;
    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 64;

    logic        clk16M = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sw = '0;
    logic [3:0]  bt = '0;
    logic [15:0] disp_val;
    logic        err;
    logic        alu_done_r = 1'b0;
    logic [15:0] alu_res_r = '0;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    calc_op_sequencer_if alu_if ();
    assign alu_if.alu_done   = alu_done_r;
    assign alu_if.alu_result = alu_res_r;

    calc_op_sequencer #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
        .clk16M   (clk16M),
        .rst      (rst),
        .sw       (sw),
        .bt       (bt),
        .alu      (alu_if.master),
        .disp_val (disp_val),
        .err      (err)
    );

    initial forever #5 clk16M = ~clk16M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model state: raw-button pipeline, per-button stable-run lengths, command registers.
    logic [3:0]  m_s1 = '0, m_s2 = '0, m_acc = '0, m_ev = '0;
    int          m_run [4];
    int          ev_seen [4];
    logic [7:0]  m_a = '0, m_b = '0;
    int          m_op = 0;
    logic [15:0] m_disp = '0;
    bit          m_err = 1'b0;
    int          m_phase = 0;   // 0 waiting for commands, 1 launching, 2 ALU running
    int          m_wait = 0;
    bit          m_start = 1'b0;

    always @(posedge clk16M) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_acc = '0; m_ev = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_a = '0; m_b = '0; m_op = 0; m_disp = '0; m_err = 1'b0;
            m_phase = 0; m_wait = 0; m_start = 1'b0;
        end else begin
            if (m_phase == 0) begin
                if (m_ev[3]) begin
                    if (m_op == 3 && m_b == 8'd0) begin
                        m_err = 1'b1; m_disp = 16'hEEEE;
                    end else begin
                        m_phase = 1;
                    end
                end else if (m_ev[2]) begin
                    m_op = (m_op + 1) % 4; m_disp = 16'(m_op); m_err = 1'b0;
                end else if (m_ev[1]) begin
                    m_b = sw; m_disp = {8'h00, sw}; m_err = 1'b0;
                end else if (m_ev[0]) begin
                    m_a = sw; m_disp = {8'h00, sw}; m_err = 1'b0;
                end
            end else if (m_phase == 1) begin
                m_phase = 2; m_wait = 0;
            end else begin
                if (alu_if.alu_done) begin
                    m_disp = alu_if.alu_result; m_err = 1'b0; m_phase = 0;
                end else if (m_wait == TMO - 1) begin
                    m_err = 1'b1; m_disp = 16'hEEEE; m_phase = 0;
                end else begin
                    m_wait++;
                end
            end
            m_start = (m_phase == 1);
            m_ev = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_acc[i] = ~m_acc[i];
                        m_run[i] = 0;
                        if (m_acc[i]) begin
                            m_ev[i] = 1'b1;
                            ev_seen[i]++;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bt;
        end
    end

    always @(negedge clk16M) begin
        if (chk_en) begin
            chk("alu_a", 32'(alu_if.alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_if.alu_b), 32'(m_b));
            chk("alu_op", 32'(alu_if.alu_op), 32'(m_op));
            chk("alu_start", 32'(alu_if.alu_start), 32'(m_start));
            chk("disp_val", 32'(disp_val), 32'(m_disp));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    // ALU stand-in: optional fixed 3-cycle response, plus on-demand stray done pulses.
    bit          alu_respond = 1'b0;
    logic [15:0] alu_res_cfg = '0;
    int          pend = 0;
    int          force_req = 0;
    int          force_ack = 0;
    int          start_cnt = 0;

    always @(negedge clk16M) begin
        alu_done_r = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                alu_done_r = 1'b1;
                alu_res_r  = alu_res_cfg;
            end
        end
        if (force_req != force_ack) begin
            alu_done_r = 1'b1;
            force_ack  = force_req;
        end
        if (alu_if.alu_start === 1'b1) begin
            start_cnt++;
            if (alu_respond) pend = 3;
        end
    end

    task automatic press(input int idx, input logic [7:0] val);
        sw = val;
        bt[idx] = 1'b1;
        repeat (8) @(negedge clk16M);
        bt[idx] = 1'b0;
        repeat (8) @(negedge clk16M);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            ev_seen[i] = 0;
        end
        repeat (2) @(negedge clk16M);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_alu_a", 32'(alu_if.alu_a), 32'h0);
        chk("rst_alu_b", 32'(alu_if.alu_b), 32'h0);
        chk("rst_alu_op", 32'(alu_if.alu_op), 32'h0);
        chk("rst_alu_start", 32'(alu_if.alu_start), 32'h0);
        chk("rst_disp", 32'(disp_val), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // 1: bounce shorter than the debounce window, then a clean hold
        for (int i = 0; i < 10; i++) begin
            bt[0] = ~bt[0];
            repeat (2) @(negedge clk16M);
        end
        chk("bounce_no_event", 32'(ev_seen[0]), 32'd0);
        chk("bounce_alu_a", 32'(alu_if.alu_a), 32'h0);
        sw = 8'h2A;
        bt[0] = 1'b1;
        repeat (10) @(negedge clk16M);
        chk("hold_event", 32'(ev_seen[0]), 32'd1);
        chk("hold_alu_a", 32'(alu_if.alu_a), 32'h2A);
        chk("hold_disp", 32'(disp_val), 32'h002A);
        bt[0] = 1'b0;
        repeat (10) @(negedge clk16M);
        chk("release_no_event", 32'(ev_seen[0]), 32'd1);

        // 2: add flow with a 3-cycle ALU
        press(0, 8'h05);
        press(1, 8'h07);
        alu_res_cfg = 16'h000C;
        alu_respond = 1'b1;
        s0 = start_cnt;
        press(3, 8'h00);
        repeat (4) @(negedge clk16M);
        chk("add_start_once", 32'(start_cnt - s0), 32'd1);
        chk("add_disp", 32'(disp_val), 32'h000C);
        chk("add_err", 32'(err), 32'h0);

        // 3: operator wrap and divide by zero
        for (int i = 0; i < 4; i++) begin
            press(2, 8'h00);
            chk("op_disp", 32'(disp_val), 32'((i + 1) % 4));
        end
        for (int i = 0; i < 3; i++) press(2, 8'h00);
        chk("op_is_div", 32'(alu_if.alu_op), 32'd3);
        press(1, 8'h00);
        s0 = start_cnt;
        press(3, 8'h00);
        repeat (4) @(negedge clk16M);
        chk("div0_no_start", 32'(start_cnt - s0), 32'd0);
        chk("div0_err", 32'(err), 32'h1);
        chk("div0_disp", 32'(disp_val), 32'hEEEE);
        press(1, 8'h02);
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_disp", 32'(disp_val), 32'h0002);

        // 4: silent ALU, button lockout while busy, timeout, late done
        alu_respond = 1'b0;
        s0 = start_cnt;
        press(3, 8'h00);
        press(0, 8'h55);
        chk("busy_lockout_a", 32'(alu_if.alu_a), 32'h05);
        k = 0;
        while (err !== 1'b1 && k < 100) begin
            @(negedge clk16M);
            k++;
        end
        chk("timeout_seen", 32'(err), 32'h1);
        chk("timeout_disp", 32'(disp_val), 32'hEEEE);
        chk("timeout_one_start", 32'(start_cnt - s0), 32'd1);
        force_req++;
        repeat (4) @(negedge clk16M);
        chk("late_done_disp", 32'(disp_val), 32'hEEEE);
        chk("late_done_err", 32'(err), 32'h1);

        // 5: simultaneous load-B and execute, then reset while busy
        s0 = start_cnt;
        sw = 8'h99;
        bt[1] = 1'b1;
        bt[3] = 1'b1;
        repeat (8) @(negedge clk16M);
        bt = '0;
        repeat (4) @(negedge clk16M);
        chk("prio_b_kept", 32'(alu_if.alu_b), 32'h02);
        chk("prio_exec", 32'(start_cnt - s0), 32'd1);
        rst = 1'b1;
        @(negedge clk16M);
        rst = 1'b0;
        force_req++;
        repeat (4) @(negedge clk16M);
        chk("post_rst_a", 32'(alu_if.alu_a), 32'h0);
        chk("post_rst_b", 32'(alu_if.alu_b), 32'h0);
        chk("post_rst_op", 32'(alu_if.alu_op), 32'h0);
        chk("post_rst_start", 32'(alu_if.alu_start), 32'h0);
        chk("post_rst_disp", 32'(disp_val), 32'h0);
        chk("post_rst_err", 32'(err), 32'h0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
